board_move_ctrl: RTL and testbench
==================================

Name: board_move_ctrl

Overview:
- Turn-based movement sequencer for the two board-game pieces (player 0 and player 1).
- Accepts a dice roll for the player whose turn it is and animates that piece tile-by-tile across a serpentine 8x8 board, one pixel step per VGA frame.
- Outputs the registered top-left sprite coordinates that feed the two 16x16 player sprite renderers, plus turn and winner status for the UI.

Parameters:
- TILE_PX, 32, tile edge in pixels; must be a multiple of HOP_FRAMES.
- COLS, 8, board columns.
- ROWS, 8, board rows.
- ORIGIN_X, 192, screen x of the board's left edge.
- ORIGIN_Y, 112, screen y of the board's top edge.
- HOP_FRAMES, 8, frame ticks per one-tile hop; the step size is PIX = TILE_PX/HOP_FRAMES (default 4).

Ports:
- clk  in  1  pixel/system clock.
- reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per VGA frame (end of active video).
- move_req  in  1  one-cycle roll request.
- move_steps  in  3  roll value 1..7; 0 is ignored.
- busy  out  1  high while a move is in progress.
- move_done  out  1  one-cycle pulse when the piece lands.
- turn  out  1  player allowed to roll (0/1).
- game_over  out  1  a piece has reached the last tile.
- winner  out  1  player that finished; valid only when game_over=1.
- p0_x, p0_y  out  10 each  player 0 sprite top-left.
- p1_x, p1_y  out  10 each  player 1 sprite top-left.
- p0_tile, p1_tile  out  6 each  tile index 0..COLS*ROWS-1.

Behaviour:
- Board geometry:
  - Tile 0 is at the bottom-left.
  - Even rows run left to right; odd rows run right to left; row r is at screen row ROWS-1-r.
  - Sprite x = ORIGIN_X + col*TILE_PX + (TILE_PX-16)/2; sprite y = ORIGIN_Y + (ROWS-1-row)*TILE_PX + (TILE_PX-16)/2.
  - Track col/row incrementally with counters; no divider, no multiplier in the datapath.
- Reset: all outputs 0 except both pieces at tile 0, i.e. p0/p1 = (200,344) with defaults.
- States: IDLE, HOP, LAND, OVER.
- IDLE:
  - move_req=1 with move_steps!=0 latches steps_left=move_steps and mover=turn, then goes to HOP.
  - busy=1 from the next cycle.
  - A frame_tick in the same cycle as the accepting move_req is not counted.
  - move_req with move_steps=0 is ignored.
- HOP:
  - On each frame_tick, sub (0..HOP_FRAMES-1) increments.
  - The mover's coordinate moves PIX pixels toward the next tile: +x on even rows, -x on odd rows, -y on a row change (last column of the row).
  - On the tick where sub==HOP_FRAMES-1: sub clears, tile+1, steps_left-1, and the coordinate snaps to the computed tile position, so there is no accumulated error.
  - If steps_left becomes 0 or tile becomes COLS*ROWS-1, go to LAND.
  - Cycles without frame_tick hold all state.
- LAND (one cycle):
  - move_done=1 and busy=0 on the next cycle.
  - If the mover is on the last tile: game_over=1, winner=mover, go to OVER.
  - Otherwise turn toggles and the state returns to IDLE.
- Overshoot: the piece clamps at the last tile; the remaining steps are discarded.
- move_req while busy, in LAND or in OVER: ignored, no queuing.
- OVER: holds all outputs until reset.
- The non-moving piece never changes.
- Both pieces may share a tile; the coordinates are identical and the renderers resolve drawing priority.
- Reset mid-move returns everything to reset values on the next cycle.
- All outputs are registered.

Optional Feature:
- Macro: HOP_ARC_EN.
- Defined: during HOP, the mover's y output is reduced by lift = 2*min(sub, HOP_FRAMES-sub) pixels, a jump arc peaking at 8 px with defaults.
  - lift is 0 at sub=0 and at landing.
  - The tile-position registers are unaffected; only the output is offset.
- Undefined: no lift; the y output is unchanged.

Test Plan:
- Reset, then run 10 frame_ticks with no request -> p0=p1=(200,344); tiles 0; turn=0; busy=0; game_over=0; move_done never pulses.
- P0 move_steps=3 -> busy the next cycle; after 24 ticks p0=(296,344), p0_tile=3; one move_done pulse; turn=1; p1 unchanged.
- Piece on tile 7 at (424,344), roll 1 -> x stays 424, y steps 344→340…→312 over 8 ticks; tile 8; the next move goes -x.
- Piece on tile 60, roll 6 -> stops at tile 63, (200,120); game_over=1; winner=mover; a following move_req is ignored.
- move_req (roll 5) during a P0 hop, plus move_steps=0 in IDLE -> both ignored; P0 completes its original roll; turn toggles exactly once.
- reset asserted at sub=4 mid-hop -> next cycle all outputs at reset values; with HOP_ARC_EN, y lift=8 observed at sub=4 of a normal hop.

Source files
------------

// File: rtl/board_move_ctrl.sv
// Turn-based movement sequencer for two board pieces on a serpentine COLSxROWS board.
// Optional macro HOP_ARC_EN lifts the moving sprite along a jump arc during each hop.
module board_move_ctrl #(
  parameter int TILE_PX    = 32,
  parameter int COLS       = 8,
  parameter int ROWS       = 8,
  parameter int ORIGIN_X   = 192,
  parameter int ORIGIN_Y   = 112,
  parameter int HOP_FRAMES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       move_req,
  input  logic [2:0] move_steps,
  output logic       busy,
  output logic       move_done,
  output logic       turn,
  output logic       game_over,
  output logic       winner,
  output logic [9:0] p0_x,
  output logic [9:0] p0_y,
  output logic [9:0] p1_x,
  output logic [9:0] p1_y,
  output logic [5:0] p0_tile,
  output logic [5:0] p1_tile
);

  localparam int SW = (HOP_FRAMES > 1) ? $clog2(HOP_FRAMES) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [9:0]    X0        = 10'(ORIGIN_X + (TILE_PX - 16) / 2);
  localparam logic [9:0]    Y0        = 10'(ORIGIN_Y + (ROWS - 1) * TILE_PX + (TILE_PX - 16) / 2);
  localparam logic [9:0]    PIX_V     = 10'(TILE_PX / HOP_FRAMES);
  localparam logic [9:0]    TILE_V    = 10'(TILE_PX);
  localparam logic [5:0]    LAST_TILE = 6'(COLS * ROWS - 1);
  localparam logic [SW-1:0] SUB_LAST  = SW'(HOP_FRAMES - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, HOP = 2'd1, LAND = 2'd2, OVER = 2'd3} state_t;

  state_t        state_r, state_s;
  logic [SW-1:0] sub_r, sub_s;
  logic [2:0]    steps_r, steps_s;
  logic          mover_r, mover_s;
  logic [9:0]    hx_r, hx_s, hy_r, hy_s;
  logic [5:0]    tile_r [2];
  logic [5:0]    tile_s [2];
  logic [CW-1:0] col_r [2];
  logic [CW-1:0] col_s [2];
  logic [RW-1:0] row_r [2];
  logic [RW-1:0] row_s [2];
  logic [9:0]    x_r [2];
  logic [9:0]    x_s [2];
  logic [9:0]    yb_r [2];
  logic [9:0]    yb_s [2];
  logic [9:0]    py_r [2];
  logic [9:0]    py_s [2];
  logic          busy_r, busy_s, done_r, done_s, turn_r, turn_s;
  logic          over_r, over_s, win_r, win_s;
  logic          accept_s, row_end_s, last_sub_s;

`ifdef HOP_ARC_EN
  function automatic logic [9:0] lift_px(input logic [SW-1:0] s);
    logic [9:0] up;
    logic [9:0] dn;
    logic [9:0] m;
    up = 10'(s);
    dn = 10'(HOP_FRAMES) - up;
    m  = (up < dn) ? up : dn;
    return m + m;
  endfunction
`endif

  assign accept_s   = (state_r == IDLE) && move_req && (move_steps != 3'd0);
  assign last_sub_s = (sub_r == SUB_LAST);
  // The turning end of a row is its last column in travel direction; the hop there goes up a row.
  assign row_end_s  = row_r[mover_r][0] ? (col_r[mover_r] == {CW{1'b0}})
                                        : (col_r[mover_r] == COL_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = HOP;
        else          state_s = IDLE;
      end
      HOP: begin
        if (frame_tick && last_sub_s &&
            (steps_r == 3'd1 || tile_r[mover_r] == LAST_TILE - 6'd1)) state_s = LAND;
        else state_s = HOP;
      end
      LAND: begin
        if (tile_r[mover_r] == LAST_TILE) state_s = OVER;
        else                              state_s = IDLE;
      end
      OVER:    state_s = OVER;
      default: state_s = IDLE;
    endcase
  end

  // Datapath and output next values; snapping reloads the coordinate from the hop base.
  always_comb begin
    sub_s   = sub_r;
    steps_s = steps_r;
    mover_s = mover_r;
    hx_s    = hx_r;
    hy_s    = hy_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    turn_s  = turn_r;
    over_s  = over_r;
    win_s   = win_r;
    tile_s  = tile_r;
    col_s   = col_r;
    row_s   = row_r;
    x_s     = x_r;
    yb_s    = yb_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          steps_s = move_steps;
          mover_s = turn_r;
          sub_s   = {SW{1'b0}};
          busy_s  = 1'b1;
          hx_s    = x_r[turn_r];
          hy_s    = yb_r[turn_r];
        end else begin
          busy_s  = 1'b0;
        end
      end
      HOP: begin
        if (frame_tick && last_sub_s) begin
          sub_s            = {SW{1'b0}};
          tile_s[mover_r]  = tile_r[mover_r] + 6'd1;
          steps_s          = steps_r - 3'd1;
          if (row_end_s) begin
            row_s[mover_r] = row_r[mover_r] + RW'(1'b1);
            hy_s           = hy_r - TILE_V;
          end else if (row_r[mover_r][0]) begin
            col_s[mover_r] = col_r[mover_r] - CW'(1'b1);
            hx_s           = hx_r - TILE_V;
          end else begin
            col_s[mover_r] = col_r[mover_r] + CW'(1'b1);
            hx_s           = hx_r + TILE_V;
          end
          x_s[mover_r]     = hx_s;
          yb_s[mover_r]    = hy_s;
        end else if (frame_tick) begin
          sub_s = sub_r + SW'(1'b1);
          if (row_end_s)               yb_s[mover_r] = yb_r[mover_r] - PIX_V;
          else if (row_r[mover_r][0])  x_s[mover_r]  = x_r[mover_r] - PIX_V;
          else                         x_s[mover_r]  = x_r[mover_r] + PIX_V;
        end else begin
          sub_s = sub_r;
        end
      end
      LAND: begin
        busy_s = 1'b0;
        done_s = 1'b1;
        if (tile_r[mover_r] == LAST_TILE) begin
          over_s = 1'b1;
          win_s  = mover_r;
        end else begin
          turn_s = ~turn_r;
        end
      end
      OVER:    busy_s = 1'b0;
      default: busy_s = 1'b0;
    endcase
  end

  // Sprite y output: the base row position, optionally raised by the hop arc.
  always_comb begin
    py_s = yb_s;
`ifdef HOP_ARC_EN
    if (state_s == HOP) py_s[mover_s] = yb_s[mover_s] - lift_px(sub_s);
    else                py_s[mover_s] = yb_s[mover_s];
`endif
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sub_r   <= {SW{1'b0}};
      steps_r <= 3'd0;
      mover_r <= 1'b0;
      hx_r    <= X0;
      hy_r    <= Y0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      turn_r  <= 1'b0;
      over_r  <= 1'b0;
      win_r   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        tile_r[i] <= 6'd0;
        col_r[i]  <= {CW{1'b0}};
        row_r[i]  <= {RW{1'b0}};
        x_r[i]    <= X0;
        yb_r[i]   <= Y0;
        py_r[i]   <= Y0;
      end
    end else begin
      sub_r   <= sub_s;
      steps_r <= steps_s;
      mover_r <= mover_s;
      hx_r    <= hx_s;
      hy_r    <= hy_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      turn_r  <= turn_s;
      over_r  <= over_s;
      win_r   <= win_s;
      tile_r  <= tile_s;
      col_r   <= col_s;
      row_r   <= row_s;
      x_r     <= x_s;
      yb_r    <= yb_s;
      py_r    <= py_s;
    end
  end

  assign busy      = busy_r;
  assign move_done = done_r;
  assign turn      = turn_r;
  assign game_over = over_r;
  assign winner    = win_r;
  assign p0_x      = x_r[0];
  assign p0_y      = py_r[0];
  assign p1_x      = x_r[1];
  assign p1_y      = py_r[1];
  assign p0_tile   = tile_r[0];
  assign p1_tile   = tile_r[1];

endmodule

// File: tb/tb_board_move_ctrl.sv
// Self-checking bench for board_move_ctrl: tile-level reference model, directed and random stimulus.
module tb_board_move_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       move_req = 1'b0;
  logic [2:0] move_steps = 3'd0;
  logic       busy, move_done, turn, game_over, winner;
  logic [9:0] p0_x, p0_y, p1_x, p1_y;
  logic [5:0] p0_tile, p1_tile;

  int checks = 0;
  int failures = 0;

  board_move_ctrl dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .move_req(move_req),
    .move_steps(move_steps), .busy(busy), .move_done(move_done), .turn(turn),
    .game_over(game_over), .winner(winner), .p0_x(p0_x), .p0_y(p0_y),
    .p1_x(p1_x), .p1_y(p1_y), .p0_tile(p0_tile), .p1_tile(p1_tile)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 moving, 2 landing, 3 finished.
  int m_tile [2];
  int m_phase, m_sub, m_left, m_mover;
  bit m_turn, m_busy, m_done, m_over, m_win, m_valid;

  function automatic int tile_x(int t);
    int r, p, c;
    r = t / 8;
    p = t % 8;
    c = (r % 2 == 1) ? 7 - p : p;
    return 192 + c * 32 + 8;
  endfunction

  function automatic int tile_y(int t);
    return 112 + (7 - t / 8) * 32 + 8;
  endfunction

  function automatic int arc(int s);
`ifdef HOP_ARC_EN
    return 2 * ((s < 8 - s) ? s : 8 - s);
`else
    return 0 * s;
`endif
  endfunction

  function automatic int exp_x(int i);
    int t;
    t = m_tile[i];
    if (m_phase == 1 && i == m_mover)
      return tile_x(t) + (tile_x(t + 1) - tile_x(t)) * m_sub / 8;
    return tile_x(t);
  endfunction

  function automatic int exp_y(int i);
    int t;
    t = m_tile[i];
    if (m_phase == 1 && i == m_mover)
      return tile_y(t) + (tile_y(t + 1) - tile_y(t)) * m_sub / 8 - arc(m_sub);
    return tile_y(t);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_tile[0] = 0; m_tile[1] = 0;
      m_phase = 0; m_sub = 0; m_left = 0; m_mover = 0;
      m_turn = 0; m_busy = 0; m_done = 0; m_over = 0; m_win = 0;
      m_valid = 1;
    end else if (m_valid) begin
      m_done = 0;
      case (m_phase)
        0: if (move_req && move_steps != 0) begin
             m_left = move_steps; m_mover = m_turn; m_sub = 0; m_busy = 1; m_phase = 1;
           end
        1: if (frame_tick) begin
             m_sub++;
             if (m_sub == 8) begin
               m_sub = 0;
               m_tile[m_mover]++;
               m_left--;
               if (m_left == 0 || m_tile[m_mover] == 63) m_phase = 2;
             end
           end
        2: begin
             m_busy = 0; m_done = 1;
             if (m_tile[m_mover] == 63) begin
               m_over = 1; m_win = m_mover[0]; m_phase = 3;
             end else begin
               m_turn = !m_turn; m_phase = 0;
             end
           end
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input int want);
    checks++;
    if (act !== want[31:0]) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", busy, m_busy);
      chk("move_done", move_done, m_done);
      chk("turn", turn, m_turn);
      chk("game_over", game_over, m_over);
      chk("winner", winner, m_win);
      chk("p0_tile", p0_tile, m_tile[0]);
      chk("p1_tile", p1_tile, m_tile[1]);
      chk("p0_x", p0_x, exp_x(0));
      chk("p0_y", p0_y, exp_y(0));
      chk("p1_x", p1_x, exp_x(1));
      chk("p1_y", p1_y, exp_y(1));
    end
  end

  task automatic roll(input int n);
    move_req = 1'b1;
    move_steps = n[2:0];
    @(negedge clk);
    move_req = 1'b0;
    move_steps = 3'd0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic do_move(input int n);
    int k;
    roll(n);
    chk("busy_after_req", busy, 1);
    ticks(8 * n);
    k = 0;
    while (busy === 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("move_finished_in_budget", (k < 40) ? 1 : 0, 1);
    @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    // Idle frames: nothing moves.
    ticks(10);
    chk("reset_p0_x", p0_x, 200);
    chk("reset_p0_y", p0_y, 344);
    chk("reset_p1_x", p1_x, 200);
    chk("reset_p1_y", p1_y, 344);
    chk("reset_turn", turn, 0);
    chk("reset_busy", busy, 0);

    // P0 rolls 3.
    do_move(3);
    chk("p0_x_after3", p0_x, 296);
    chk("p0_tile_after3", p0_tile, 3);
    chk("turn_after_p0", turn, 1);
    chk("p1_x_unmoved", p1_x, 200);

    // P1 to tile 7, P0 to tile 7.
    do_move(7);
    do_move(4);
    chk("p1_x_tile7", p1_x, 424);
    chk("p1_y_tile7", p1_y, 344);

    // P1 climbs from tile 7 to tile 8 one frame at a time.
    roll(1);
    for (int k = 1; k <= 8; k++) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      chk("climb_x", p1_x, 424);
      chk("climb_y", p1_y, (k == 8) ? 312 : 344 - 4 * k - arc(k));
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("p1_tile8", p1_tile, 8);

    // Zero roll ignored, then a roll during a hop ignored.
    roll(0);
    @(negedge clk);
    chk("zero_roll_ignored", busy, 0);
    roll(2);
    ticks(3);
    roll(5);
    ticks(13);
    repeat (3) @(negedge clk);
    chk("p0_tile9", p0_tile, 9);
    chk("p0_x_tile9", p0_x, 392);
    chk("p0_y_tile9", p0_y, 312);
    chk("turn_once", turn, 1);

    // Reset in the middle of a hop at sub=4.
    roll(3);
    ticks(4);
    chk("midhop_x", p1_x, 408);
    chk("midhop_y", p1_y, 312 - arc(4));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_p1_x", p1_x, 200);
    chk("rst_p1_y", p1_y, 344);
    chk("rst_p1_tile", p1_tile, 0);
    chk("rst_p0_tile", p0_tile, 0);
    chk("rst_busy", busy, 0);

    // Random play until a winner emerges, then keep poking.
    for (int c = 0; c < 12000; c++) begin
      frame_tick = ($urandom_range(0, 1) == 0);
      move_req   = ($urandom_range(0, 4) == 0);
      move_steps = 3'($urandom_range(0, 7));
      @(negedge clk);
      if (m_phase == 3 && c > 0 && ($urandom_range(0, 63) == 0)) break;
    end
    frame_tick = 1'b0;
    move_req = 1'b0;
    move_steps = 3'd0;
    @(negedge clk);

    // Directed endgame: P0 reaches 60, then overshoots to 63.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int r = 0; r < 8; r++) begin
      do_move(7);
      do_move(1);
    end
    do_move(4);
    chk("p0_tile60", p0_tile, 60);
    do_move(1);
    do_move(6);
    chk("end_p0_tile", p0_tile, 63);
    chk("end_p0_x", p0_x, 200);
    chk("end_p0_y", p0_y, 120);
    chk("end_game_over", game_over, 1);
    chk("end_winner", winner, 0);
    roll(3);
    ticks(10);
    chk("over_ignores_busy", busy, 0);
    chk("over_p1_tile", p1_tile, 9);
    chk("over_p0_tile", p0_tile, 63);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
